mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Responder end of the ready/valid memory request interface used by the pipeline for instruction fetch and data load/store. It accepts one request per cycle, performs the read or write on an internal word array, and returns exactly one in-order response per request after a fixed pipeline latency. A response queue with credit accounting applies back-pressure, so no response is ever dropped.

Parameters:
DATA_W, 32, data and response width
ADDR_W, 32, request address width (byte address)
DEPTH, 256, number of DATA_W-bit words in the array; power of two
LATENCY, 2, cycles from request accept to earliest resp_valid; must be >= 1
QDEPTH, 4, maximum outstanding requests (in pipeline + queued); must be >= 1; QDEPTH >= LATENCY+1 gives full throughput

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request this cycle
req_addr  in  ADDR_W  byte address
req_op  in  1  0 = read, 1 = write
req_wdata  in  DATA_W  write data; ignored for reads
resp_valid  out  1  response present
resp_ready  in  1  requester accepts the response
resp_data  out  DATA_W  read data; 0 for write responses

Behaviour:
- Accept: a request is taken on a rising edge with req_valid & req_ready. Response handshake: resp_valid & resp_ready.
- Word index = req_addr[log2(DEPTH)+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH*4. Bits [1:0] are ignored unless MEM_ALIGN_CHECK_EN is defined.
- Outstanding counter cnt (0..QDEPTH):
  - +1 on accept; -1 on response handshake; unchanged when both occur in the same cycle.
- req_ready = (cnt < QDEPTH) & ~reset. It is combinational from registered state and never depends on req_valid.
- Memory access happens in the accept cycle:
  - Write: updates the array at that edge.
  - Read: captures array[index] at that edge.
  - A read accepted the cycle after a write to the same word returns the new data. One port, so no same-cycle read/write conflict exists.
- Pipeline: a LATENCY-stage shift register of {valid, data}; stage 0 is loaded at accept. On leaving the last stage, the entry is pushed into a QDEPTH-entry FIFO.
- Response output:
  - When the FIFO is empty, the last-stage entry is presented directly (bypass).
  - Minimum latency is exactly LATENCY cycles: accept at edge N gives resp_valid high after edge N+LATENCY-1 and before edge N+LATENCY.
- FIFO ordering and limits:
  - Order is strictly FIFO: responses return in accept order.
  - The FIFO cannot overflow, because cnt bounds the total entries.
  - Push and pop in the same cycle are both allowed, including when the FIFO is full and when it is empty (bypass).
- resp_valid, resp_data and the FIFO head are stable while resp_valid & ~resp_ready.
- Reset (asserted at any time, including mid-transaction):
  - Immediately clears cnt, pipeline valids, FIFO pointers, resp_valid = 0, resp_data = 0, req_ready = 0.
  - In-flight requests are discarded.
  - The memory array is not reset; its contents are undefined at power-up and preserved across reset.
  - After reset deasserts, req_ready = 1 on the first cycle.
- No internal state machine beyond cnt/pipeline/FIFO: states are EMPTY (cnt = 0), BUSY (0 < cnt < QDEPTH) and FULL (cnt = QDEPTH, req_ready = 0).

Optional Feature:
Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output port resp_err (1 bit, reset 0), travelling with each response.
  - A request with req_addr[1:0] != 0 performs no array access: a write is dropped and a read does not sample the array.
  - Such a request still consumes a slot and returns an in-order response with resp_data = 0 and resp_err = 1. Aligned requests return resp_err = 0.
- Not defined: no resp_err port; address bits [1:0] are ignored and all requests access the array.

Test Plan:
1. Write 0xDEADBEEF at addr 0x10, then read 0x10 on the next cycle with resp_ready=1 -> write response data 0; read response 0xDEADBEEF appears exactly LATENCY=2 cycles after its accept; responses in order.
2. Hold resp_ready=0 and issue back-to-back reads -> exactly QDEPTH=4 accepted, then req_ready=0. Raise resp_ready -> 4 responses in order, req_ready returns 1 the cycle after the first pop.
3. At FULL (cnt=4), assert req_valid and resp_ready in the same cycle -> one pop and no accept that cycle. Next cycle: accept and pop together leave cnt unchanged at 3->3 steady state, with continuous throughput of 1/cycle and no loss.
4. Write 0x11 to addr 0x0, then read addr DEPTH*4 = 0x400 -> returns 0x11 (wrap).
5. Assert reset with 3 requests outstanding -> resp_valid drops immediately and no stale response appears after release. Read addr 0x10 afterwards -> still 0xDEADBEEF (array preserved).
6. With MEM_ALIGN_CHECK_EN: write 0x55 to 0x12, then read 0x10 -> first response resp_err=1, data 0; second returns prior contents (write was dropped) with resp_err=0.

Source files
------------

// File: rtl/mem_responder.sv
// Ready/valid memory responder: word array, fixed-latency read pipeline and an in-order response FIFO.
// Optional build macro MEM_ALIGN_CHECK_EN adds resp_err and suppresses array access for misaligned requests.
module mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              resp_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int LAST  = LATENCY - 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LATENCY-1:0] pipeVld_q;
  logic [DATA_W-1:0] pipeData_q [LATENCY];
  logic [DATA_W-1:0] fifoData_q [QDEPTH];
  logic [PTR_W-1:0]  rdPtr_q, wrPtr_q;
  logic [CNT_W-1:0]  fifoCnt_q;

  logic [IDX_W-1:0]  wordIdx;
  logic              accept, respFire, fifoEmpty, fifoPush, fifoPop;
  logic              misaligned, memWe, headVld;
  logic [DATA_W-1:0] stageData, headData;
  logic              unusedAddrBits;

  function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wordIdx = req_addr[IDX_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned     = |req_addr[1:0];
  assign unusedAddrBits = ^req_addr[ADDR_W-1:IDX_W+2];
`else
  assign misaligned     = 1'b0;
  assign unusedAddrBits = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};
`endif

  assign req_ready = (cnt_q < CNT_W'(QDEPTH)) & ~reset;
  assign accept    = req_valid & req_ready;
  assign memWe     = accept & req_op & ~misaligned;
  assign stageData = (req_op | misaligned) ? '0 : mem[wordIdx];

  // FIFO empty means the last pipeline stage is presented directly.
  assign fifoEmpty  = (fifoCnt_q == '0);
  assign headVld    = ~fifoEmpty | pipeVld_q[LAST];
  assign headData   = fifoEmpty ? pipeData_q[LAST] : fifoData_q[rdPtr_q];
  assign resp_valid = headVld;
  assign resp_data  = headVld ? headData : '0;
  assign respFire   = resp_valid & resp_ready;
  assign fifoPop    = respFire & ~fifoEmpty;
  assign fifoPush   = pipeVld_q[LAST] & ~(fifoEmpty & resp_ready);

  always_comb begin
    cnt_d = cnt_q;
    if (accept & ~respFire)      cnt_d = cnt_q + 1'b1;
    else if (~accept & respFire) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (memWe) mem[wordIdx] <= req_wdata;
    if (fifoPush) fifoData_q[wrPtr_q] <= pipeData_q[LAST];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      pipeVld_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipeData_q[i] <= '0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      fifoCnt_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      pipeVld_q[0]  <= accept;
      pipeData_q[0] <= stageData;
      for (int i = 1; i < LATENCY; i++) begin
        pipeVld_q[i]  <= pipeVld_q[i-1];
        pipeData_q[i] <= pipeData_q[i-1];
      end
      if (fifoPush) wrPtr_q <= incPtr(wrPtr_q);
      if (fifoPop)  rdPtr_q <= incPtr(rdPtr_q);
      if (fifoPush & ~fifoPop)      fifoCnt_q <= fifoCnt_q + 1'b1;
      else if (fifoPop & ~fifoPush) fifoCnt_q <= fifoCnt_q - 1'b1;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Error flag rides alongside the data through pipeline and FIFO.
  logic [LATENCY-1:0] pipeErr_q;
  logic [QDEPTH-1:0]  fifoErr_q;
  logic               headErr;

  assign headErr  = fifoEmpty ? pipeErr_q[LAST] : fifoErr_q[rdPtr_q];
  assign resp_err = headVld & headErr;

  always_ff @(posedge clk) begin
    if (fifoPush) fifoErr_q[wrPtr_q] <= pipeErr_q[LAST];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipeErr_q <= '0;
    end else begin
      pipeErr_q[0] <= accept & misaligned;
      for (int i = 1; i < LATENCY; i++) pipeErr_q[i] <= pipeErr_q[i-1];
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (default parameters).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_op;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
`ifdef MEM_ALIGN_CHECK_EN
  logic        resp_err;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_op     (req_op),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .resp_err   (resp_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic applyStimulus(input logic op, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    for (int i = 0; i < 10 && !req_ready; i++) tick;
    checkOutput("accept", {31'd0, req_ready}, 32'd1);
    tick;
    req_valid = 1'b0;
  endtask

  task automatic waitResp(input string tag, input logic [31:0] expData);
    for (int i = 0; i < 10 && !resp_valid; i++) tick;
    checkOutput({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    checkOutput(tag, resp_data, expData);
    tick;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] expQ[$];
    int accepted;
    int sent;
    int stale;

    reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_addr = '0;
    req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_ready", {31'd0, req_ready}, 32'd1);
    tick;

    // Write then read back-to-back, checking exact latency.
    resp_ready = 1'b1;
    req_valid = 1'b1; req_op = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    tick;
    req_op = 1'b0; req_wdata = '0;
    checkOutput("t1_no_early_resp", {31'd0, resp_valid}, 32'd0);
    tick;
    req_valid = 1'b0;
    checkOutput("t1_wr_resp_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("t1_wr_resp_data", resp_data, 32'd0);
    tick;
    checkOutput("t1_rd_resp_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("t1_rd_resp_data", resp_data, 32'hDEADBEEF);
    tick;
    checkOutput("t1_idle", {31'd0, resp_valid}, 32'd0);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 32'h20 + 32'(4 * k), 32'hA0 + 32'(k));
      waitResp("preload_wr", 32'd0);
    end

    // Back-pressure: only four reads fit.
    resp_ready = 1'b0;
    accepted = 0;
    req_valid = 1'b1; req_op = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr = 32'h20 + 32'(4 * accepted);
      if (req_ready) accepted++;
      tick;
    end
    req_valid = 1'b0;
    checkOutput("t2_accepted", 32'(accepted), 32'd4);
    checkOutput("t2_full_ready", {31'd0, req_ready}, 32'd0);
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("t2_resp_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("t2_resp_data", resp_data, 32'hA0 + 32'(k));
      tick;
      if (k == 0) checkOutput("t2_ready_after_pop", {31'd0, req_ready}, 32'd1);
    end
    checkOutput("t2_drained", {31'd0, resp_valid}, 32'd0);

    // Full queue, then simultaneous accept and pop at steady state.
    resp_ready = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 32'h20 + 32'(4 * k), 32'd0);
    tick; tick;
    checkOutput("t3_full", {31'd0, req_ready}, 32'd0);
    expQ = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    sent = 0;
    resp_ready = 1'b1; req_valid = 1'b1; req_op = 1'b0;
    for (int k = 0; k < 10; k++) begin
      req_addr = 32'h20 + 32'(4 * (sent % 4));
      checkOutput("t3_ready", {31'd0, req_ready}, (k == 0) ? 32'd0 : 32'd1);
      checkOutput("t3_resp_valid", {31'd0, resp_valid}, 32'd1);
      if (resp_valid) checkOutput("t3_resp_data", resp_data, expQ.pop_front());
      if (req_ready) begin
        expQ.push_back(32'hA0 + 32'(sent % 4));
        sent++;
      end
      tick;
    end
    req_valid = 1'b0;
    for (int n = 0; n < 20 && expQ.size() > 0; n++) begin
      if (resp_valid) checkOutput("t3_drain_data", resp_data, expQ.pop_front());
      tick;
    end
    checkOutput("t3_drain_left", 32'(expQ.size()), 32'd0);
    checkOutput("t3_idle", {31'd0, resp_valid}, 32'd0);

    // Address wrap modulo DEPTH*4.
    applyStimulus(1'b1, 32'h0, 32'h11);
    waitResp("t4_wr", 32'd0);
    applyStimulus(1'b0, 32'h400, 32'd0);
    waitResp("t4_wrap_rd", 32'h11);

    // Reset mid-flight discards responses but keeps the array.
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 32'h20 + 32'(4 * k), 32'd0);
    tick;
    checkOutput("t5_pending", {31'd0, resp_valid}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("t5_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("t5_rst_resp_data", resp_data, 32'd0);
    checkOutput("t5_rst_req_ready", {31'd0, req_ready}, 32'd0);
    tick; tick;
    reset = 1'b0;
    #1;
    checkOutput("t5_post_rst_ready", {31'd0, req_ready}, 32'd1);
    tick;
    resp_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) stale++;
      tick;
    end
    checkOutput("t5_no_stale", 32'(stale), 32'd0);
    applyStimulus(1'b0, 32'h10, 32'd0);
    waitResp("t5_preserved", 32'hDEADBEEF);

`ifdef MEM_ALIGN_CHECK_EN
    applyStimulus(1'b1, 32'h12, 32'h55);
    for (int i = 0; i < 10 && !resp_valid; i++) tick;
    checkOutput("t6_mis_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("t6_mis_data", resp_data, 32'd0);
    checkOutput("t6_mis_err", {31'd0, resp_err}, 32'd1);
    tick;
    applyStimulus(1'b0, 32'h10, 32'd0);
    for (int i = 0; i < 10 && !resp_valid; i++) tick;
    checkOutput("t6_rd_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("t6_rd_data", resp_data, 32'hDEADBEEF);
    checkOutput("t6_rd_err", {31'd0, resp_err}, 32'd0);
    tick;
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
